instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the main decoder in the cache-integrated RV32I core.
- Holds the PC and issues word fetches to the instruction cache over a request/response handshake, stalling while the cache misses.
- Presents the fetched instruction and its opcode field to the decoder.
- Advances the PC to PC+4 or to the branch/jump target using the decoder's PCSrc.

---
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: holds the PC, fetches words from the I-cache over a req/resp
// handshake and presents the instruction (or a NOP bubble) to the decoder.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PCSrc,
    input  logic [31:0]      PCTarget,
    input  logic             Stall,
    output logic             IC_Req,
    output logic [31:0]      IC_Addr,
    input  logic             IC_Ready,
    input  logic             IC_RespValid,
    input  logic [31:0]      IC_RespData,
    output logic [31:0]      Instr,
    output logic [6:0]       OP6_0,
    output logic             InstrValid,
    output logic [31:0]      PC,
    output logic [31:0]      PCPlus4,
    output logic             MisalignErr,
    output logic [CNT_W-1:0] MissCycles
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic             r_misalign;
    logic [CNT_W-1:0] r_miss;
    logic [31:0]      w_pc_plus4;
    logic             w_advance;
    logic             w_capture;
    logic             w_req;
    logic             w_valid;
    logic [31:0]      w_instr;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_advance  = (r_state == S_VALID) && !Stall;
    assign w_capture  = ((r_state == S_REQ) && IC_Ready && IC_RespValid) ||
                        ((r_state == S_WAIT) && IC_RespValid);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_REQ;
            S_REQ: begin
                if (IC_Ready && IC_RespValid) begin
                    w_next = S_VALID;
                end else if (IC_Ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (IC_RespValid) begin
                    w_next = S_VALID;
                end
            end
            S_VALID: begin
                if (!Stall) begin
                    w_next = S_REQ;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Everything outside VALID looks like a NOP bubble to the decoder.
    always_comb begin
        w_req   = 1'b0;
        w_valid = 1'b0;
        w_instr = NOP_INSTR;
        case (r_state)
            S_REQ:   w_req = 1'b1;
            S_VALID: begin
                w_valid = 1'b1;
                w_instr = r_instr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
            r_miss     <= '0;
        end else begin
            if (w_advance) begin
                r_pc <= PCSrc ? {PCTarget[31:2], 2'b00} : w_pc_plus4;
            end
            if (w_advance && PCSrc && (PCTarget[1:0] != 2'b00)) begin
                r_misalign <= 1'b1;
            end
            if ((r_state == S_WAIT) && (r_miss != {CNT_W{1'b1}})) begin
                r_miss <= r_miss + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Fetched word holder; only meaningful in VALID, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (w_capture) begin
            r_instr <= IC_RespData;
        end
    end

    assign IC_Req      = w_req;
    assign IC_Addr     = r_pc;
    assign Instr       = w_instr;
    assign OP6_0       = w_instr[6:0];
    assign InstrValid  = w_valid;
    assign PC          = r_pc;
    assign PCPlus4     = w_pc_plus4;
    assign MisalignErr = r_misalign;
    assign MissCycles  = r_miss;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: acts as the I-cache and decoder, tracking the expected
// PC stream, fetched words, miss total and misalign flag per transaction.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        Stall;
    logic        IC_Req;
    logic [31:0] IC_Addr;
    logic        IC_Ready;
    logic        IC_RespValid;
    logic [31:0] IC_RespData;
    logic [31:0] Instr;
    logic [6:0]  OP6_0;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        MisalignErr;
    logic [15:0] MissCycles;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;
    logic        exp_mis;
    int unsigned exp_miss;

    always #5 CLK = ~CLK;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP),
        .CNT_W    (16)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .Stall       (Stall),
        .IC_Req      (IC_Req),
        .IC_Addr     (IC_Addr),
        .IC_Ready    (IC_Ready),
        .IC_RespValid(IC_RespValid),
        .IC_RespData (IC_RespData),
        .Instr       (Instr),
        .OP6_0       (OP6_0),
        .InstrValid  (InstrValid),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .MisalignErr (MisalignErr),
        .MissCycles  (MissCycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int unsigned sat16(input int unsigned v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".vld"}, {31'b0, InstrValid}, 32'd0);
        chk({tag, ".instr"}, Instr, NOP);
        chk({tag, ".op"}, {25'b0, OP6_0}, 32'h13);
    endtask

    task automatic chk_arch(input string tag);
        chk({tag, ".pc"}, PC, exp_pc);
        chk({tag, ".addr"}, IC_Addr, exp_pc);
        chk({tag, ".pc4"}, PCPlus4, exp_pc + 32'd4);
        chk({tag, ".mis"}, {31'b0, MisalignErr}, {31'b0, exp_mis});
    endtask

    // One full fetch transaction starting in REQ: rdly cycles before the cache accepts,
    // wdly cycles of miss (0 = same-cycle hit), nstall stalled cycles in VALID, then redirect.
    task automatic fetch(input int rdly, input int wdly, input int nstall,
                         input bit take, input logic [31:0] tgt);
        logic [31:0] w;
        w = mem_word(exp_pc);
        for (int i = 0; i < rdly; i++) begin
            IC_Ready = 1'b0; IC_RespValid = 1'($urandom); IC_RespData = $urandom;
            Stall = 1'($urandom); PCSrc = 1'($urandom); PCTarget = $urandom;
            chk("req_wait.req", {31'b0, IC_Req}, 32'd1);
            chk_bubble("req_wait");
            chk_arch("req_wait");
            chk("req_wait.miss", {16'b0, MissCycles}, sat16(exp_miss));
            step();
        end
        IC_Ready = 1'b1;
        IC_RespValid = (wdly == 0);
        IC_RespData = (wdly == 0) ? w : $urandom;
        chk("req.req", {31'b0, IC_Req}, 32'd1);
        chk_bubble("req");
        chk_arch("req");
        step();
        for (int i = 1; i <= wdly; i++) begin
            IC_Ready = 1'($urandom);
            IC_RespValid = (i == wdly);
            IC_RespData = (i == wdly) ? w : $urandom;
            chk("wait.req", {31'b0, IC_Req}, 32'd0);
            chk_bubble("wait");
            chk("wait.miss", {16'b0, MissCycles}, sat16(exp_miss + i - 1));
            chk("wait.pc", PC, exp_pc);
            step();
        end
        exp_miss = sat16(exp_miss + wdly);
        for (int i = 0; i <= nstall; i++) begin
            IC_Ready = 1'($urandom); IC_RespValid = 1'($urandom); IC_RespData = $urandom;
            if (i < nstall) begin
                Stall = 1'b1; PCSrc = 1'($urandom); PCTarget = $urandom;
            end else begin
                Stall = 1'b0; PCSrc = take; PCTarget = tgt;
            end
            chk("valid.req", {31'b0, IC_Req}, 32'd0);
            chk("valid.vld", {31'b0, InstrValid}, 32'd1);
            chk("valid.instr", Instr, w);
            chk("valid.op", {25'b0, OP6_0}, {25'b0, w[6:0]});
            chk("valid.miss", {16'b0, MissCycles}, exp_miss);
            chk_arch("valid");
            step();
        end
        if (take) begin
            if (tgt[1:0] != 2'b00) exp_mis = 1'b1;
            exp_pc = tgt & ~32'h3;
        end else begin
            exp_pc = exp_pc + 32'd4;
        end
        Stall = 1'b0; PCSrc = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".req"}, {31'b0, IC_Req}, 32'd0);
        chk_bubble(tag);
        chk({tag, ".pc"}, PC, 32'h0);
        chk({tag, ".mis"}, {31'b0, MisalignErr}, 32'd0);
        chk({tag, ".miss"}, {16'b0, MissCycles}, 32'd0);
    endtask

    initial begin
        RST = 1'b0; PCSrc = 1'b0; PCTarget = '0; Stall = 1'b0;
        IC_Ready = 1'b0; IC_RespValid = 1'b0; IC_RespData = '0;
        exp_pc = 32'h0; exp_mis = 1'b0; exp_miss = 0;

        step();
        step();
        chk_reset_state("reset");
        RST = 1'b1;
        chk_reset_state("idle");
        step();

        fetch(0, 0, 0, 1'b0, 32'h0);               // 0 -> 4, single-cycle hit
        fetch(1, 0, 0, 1'b0, 32'h0);               // 4 -> 8
        fetch(0, 5, 0, 1'b0, 32'h0);               // 8 -> C, 5-cycle miss
        fetch(0, 0, 3, 1'b0, 32'h0);               // C -> 10, stalled 3 cycles
        fetch(0, 0, 0, 1'b1, 32'h0000_0040);       // 10 -> 40 taken
        fetch(0, 0, 0, 1'b0, 32'h0);               // 40 -> 44
        fetch(0, 0, 0, 1'b1, 32'h0000_0022);       // 44 -> 20 misaligned
        fetch(0, 1, 0, 1'b1, 32'hFFFF_FFFC);       // 20 -> FFFFFFFC
        fetch(0, 0, 2, 1'b0, 32'h0);               // FFFFFFFC wraps to 0
        fetch(0, 0, 0, 1'b0, 32'h0);

        for (int k = 0; k < 150; k++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 7) != 0) t = t & ~32'h3;
            fetch(int'($urandom_range(0, 2)),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0,
                  int'($urandom_range(0, 3)), 1'($urandom), t);
        end

        // Reset while waiting on a miss; a late response must be ignored.
        IC_Ready = 1'b1; IC_RespValid = 1'b0;
        step();
        IC_Ready = 1'b0;
        step();
        step();
        RST = 1'b0;
        step();
        chk_reset_state("midmiss_rst");
        RST = 1'b1; IC_RespValid = 1'b1; IC_RespData = $urandom;
        chk_reset_state("midmiss_idle");
        step();
        IC_Ready = 1'b0;
        chk("midmiss_req.req", {31'b0, IC_Req}, 32'd1);
        chk_reset_state_req: begin
            chk_bubble("midmiss_req");
            chk("midmiss_req.addr", IC_Addr, 32'h0);
            chk("midmiss_req.miss", {16'b0, MissCycles}, 32'd0);
        end
        step();
        IC_RespValid = 1'b0;
        exp_pc = 32'h0; exp_mis = 1'b0; exp_miss = 0;
        fetch(0, 0, 0, 1'b0, 32'h0);
        fetch(0, 2, 1, 1'b1, 32'h0000_0100);
        fetch(0, 0, 0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
